// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL types and helpers for the responder slice.
//   tl_a_t    : A-channel request, 80 bits packed (opcode..data, MSB first)
//   tl_d_t    : D-channel response, 45 bits packed (opcode..data, MSB first)
//   lane_mask : byte lanes a naturally aligned access of a given size covers
package tl_ul_pkg;

    localparam int unsigned SRC_W = 4;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITH       = 3'd2;
    localparam logic [2:0] A_LOGIC       = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_INTENT      = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic [31:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [1:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic             denied;
        logic             corrupt;
        logic [31:0]      data;
    } tl_d_t;

    // Lanes touched by an aligned access; size 3 never passes alignment so
    // its value here is irrelevant.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] lanes;
        lanes = 4'hF;
        case (size)
            2'd0:    lanes = 4'b0001 << addr;
            2'd1:    lanes = addr[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'hF;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/tl_ul_mem.sv
// tl_ul_mem: 2^MEM_AW x 32-bit word memory, synchronous byte-enabled write,
// combinational read. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   addr  : word index (shared by read and write)
//   be    : byte write enables, bit i enables wdata[8i+7:8i]
//   wdata : write data
//   rdata : full word at addr (combinational)
module tl_ul_mem #(
    parameter int unsigned MEM_AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tl_ul_responder.sv
// tl_ul_responder: TileLink-UL responder backed by a byte-enabled word memory.
// Pops one A request, executes it, pushes one D response; one transaction
// every three cycles with no overlap (IDLE -> EXEC -> RESP).
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   a_empty : A-request FIFO empty
//   a_data  : A-request FIFO head (packed tl_a_t), valid when a_empty=0
//   a_rd_en : pop A-request FIFO
//   d_full  : D-response FIFO full
//   d_wr_en : push D-response FIFO
//   d_data  : D-response (packed tl_d_t)
// BASE_ADDR must be aligned to the window size (4 * 2^MEM_AW bytes).
module tl_ul_responder
    import tl_ul_pkg::*;
#(
    parameter int unsigned MEM_AW    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_empty,
    input  logic [79:0] a_data,
    output logic        a_rd_en,
    input  logic        d_full,
    output logic        d_wr_en,
    output logic [44:0] d_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_next;
    tl_a_t  req;
    tl_d_t  resp, resp_next;

    logic [31:0]       offset;
    logic [MEM_AW-1:0] word_idx;
    logic              in_range, aligned, mask_ok, ok;
    logic [3:0]        lanes;
    logic              is_put;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    // ---------------------------------------------------------------
    // State, request and response registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            req   <= '0;
            resp  <= '0;
        end else begin
            state <= state_next;
            if (a_rd_en) begin
                req <= tl_a_t'(a_data);
            end
            if (state == EXEC) begin
                resp <= resp_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Next state and handshakes
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        a_rd_en    = 1'b0;
        d_wr_en    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset_n so the FIFO is never popped while in reset.
                if (!a_empty && reset_n) begin
                    a_rd_en    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (!d_full) begin
                    d_wr_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign d_data = resp;

    // ---------------------------------------------------------------
    // Decode of the captured request
    // ---------------------------------------------------------------
    // Modular subtraction makes the range test a single "high bits zero"
    // check, which stays correct even when the window ends at 2^32.
    assign offset   = req.address - BASE_ADDR;
    assign in_range = (offset >> (MEM_AW + 2)) == '0;
    assign word_idx = offset[MEM_AW+1:2];
    assign lanes    = lane_mask(req.size, req.address[1:0]);

    always_comb begin
        aligned = 1'b0;
        case (req.size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~req.address[0];
            2'd2:    aligned = req.address[1:0] == 2'b00;
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        if (req.opcode == A_PUT_PARTIAL) begin
            mask_ok = (req.mask != 4'h0) && ((req.mask & ~lanes) == 4'h0);
        end else begin
            mask_ok = req.mask == lanes;
        end
    end

    assign ok     = in_range & aligned & mask_ok;
    assign is_put = (req.opcode == A_PUT_FULL) || (req.opcode == A_PUT_PARTIAL);
    assign mem_we = (state == EXEC) && ok && is_put;

    // ---------------------------------------------------------------
    // Response formation
    // ---------------------------------------------------------------
    always_comb begin
        resp_next         = '0;
        resp_next.opcode  = D_ACK;
        resp_next.size    = req.size;
        resp_next.source  = req.source;
        case (req.opcode)
            A_PUT_FULL, A_PUT_PARTIAL: begin
                resp_next.denied = ~ok;
            end
            A_GET: begin
                resp_next.opcode = D_ACK_DATA;
                if (ok) begin
                    resp_next.data = mem_rdata;
                end else begin
                    resp_next.denied  = 1'b1;
                    resp_next.corrupt = 1'b1;
                end
            end
            A_INTENT: begin
                resp_next.opcode = D_HINT_ACK;
            end
            default: begin
                resp_next.denied = 1'b1;
            end
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{req.param, offset[1:0]};

    tl_ul_mem #(
        .MEM_AW(MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .be    (req.mask),
        .wdata (req.data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_tl_ul_responder.sv
// Scoreboard bench for tl_ul_responder: a behavioural byte-array model
// predicts each response when the request is queued; an independent
// monitor compares every D push against the queue.
module tb_tl_ul_responder;
    import tl_ul_pkg::*;

    localparam int unsigned MEM_AW = 6;
    localparam logic [31:0] BASE   = 32'h0000_4000;
    localparam int unsigned NBYTES = 4 << MEM_AW;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_empty;
    logic [79:0] a_data;
    logic        a_rd_en;
    logic        d_full;
    logic        d_wr_en;
    logic [44:0] d_data;

    always #5 clk = ~clk;

    tl_ul_responder #(
        .MEM_AW   (MEM_AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a_empty (a_empty),
        .a_data  (a_data),
        .a_rd_en (a_rd_en),
        .d_full  (d_full),
        .d_wr_en (d_wr_en),
        .d_data  (d_data)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    tl_a_t afifo[$];
    tl_d_t expq[$];
    byte unsigned ref_mem [NBYTES];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Bytes covered by an access of 2^size bytes starting at addr.
    function automatic logic [3:0] lanes_of(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] l;
        int unsigned off, n;
        off = addr[1:0];
        n   = 1 << size;
        for (int unsigned b = 0; b < 4; b++) l[b] = (b >= off) && (b < off + n);
        return l;
    endfunction

    function automatic tl_d_t model(input tl_a_t r);
        tl_d_t d;
        longint unsigned a, lo, hi;
        int unsigned n, w;
        logic [3:0] lanes;
        logic [31:0] rel;
        bit in_range, aligned, mask_ok, ok;
        a  = r.address;
        lo = BASE;
        hi = longint'(BASE) + NBYTES;
        in_range = (a >= lo) && (a < hi);
        n        = 1 << r.size;
        aligned  = (r.size != 2'd3) && ((a % n) == 0);
        lanes    = lanes_of(r.size, r.address);
        if (r.opcode == A_PUT_PARTIAL) mask_ok = (r.mask != 0) && ((r.mask & ~lanes) == 0);
        else mask_ok = (r.mask == lanes);
        ok  = in_range && aligned && mask_ok;
        rel = r.address - BASE;
        w   = {rel[31:2], 2'b00};
        d = '0;
        d.size   = r.size;
        d.source = r.source;
        case (r.opcode)
            A_PUT_FULL, A_PUT_PARTIAL: begin
                d.opcode = D_ACK;
                d.denied = !ok;
                if (ok)
                    for (int unsigned b = 0; b < 4; b++)
                        if (r.mask[b]) ref_mem[w+b] = r.data[b*8 +: 8];
            end
            A_GET: begin
                d.opcode = D_ACK_DATA;
                if (ok) d.data = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
                else begin
                    d.denied  = 1'b1;
                    d.corrupt = 1'b1;
                end
            end
            A_INTENT: d.opcode = D_HINT_ACK;
            default: begin
                d.opcode = D_ACK;
                d.denied = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic tl_a_t mk(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                                 input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        tl_a_t r;
        r = '0;
        r.opcode = op; r.size = size; r.source = src;
        r.address = addr; r.mask = mask; r.data = data;
        return r;
    endfunction

    function automatic tl_a_t rand_req();
        tl_a_t r;
        int unsigned sel;
        r = '0;
        r.param  = 3'($urandom);
        r.source = 4'($urandom);
        r.data   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel <= 2)      r.opcode = A_GET;
        else if (sel <= 4) r.opcode = A_PUT_FULL;
        else if (sel <= 6) r.opcode = A_PUT_PARTIAL;
        else if (sel == 7) r.opcode = A_INTENT;
        else               r.opcode = 3'($urandom);
        sel = $urandom_range(0, 9);
        if (sel <= 7)      r.address = BASE + $urandom_range(0, NBYTES - 1);
        else if (sel == 8) r.address = BASE + NBYTES + $urandom_range(0, 15);
        else               r.address = BASE - $urandom_range(1, 16);
        r.size = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) r.size = 2'd3;
        if ($urandom_range(0, 4) != 0) begin
            if (r.size == 2'd1) r.address[0] = 1'b0;
            if (r.size == 2'd2) r.address[1:0] = 2'b00;
        end
        r.mask = lanes_of(r.size, r.address);
        if (r.opcode == A_PUT_PARTIAL && $urandom_range(0, 1) == 1) r.mask = r.mask & 4'($urandom);
        if ($urandom_range(0, 7) == 0) r.mask = 4'($urandom);
        return r;
    endfunction

    task automatic issue(input tl_a_t r);
        afifo.push_back(r);
        expq.push_back(model(r));
    endtask

    // Directed form: hand-derived expectation, model still tracks memory.
    task automatic issue_exp(input tl_a_t r, input tl_d_t e);
        tl_d_t unused_m;
        unused_m = model(r);
        afifo.push_back(r);
        expq.push_back(e);
    endtask

    function automatic tl_d_t dresp(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                                    input bit denied, input bit corrupt, input logic [31:0] data);
        tl_d_t d;
        d = '0;
        d.opcode = op; d.size = size; d.source = src;
        d.denied = denied; d.corrupt = corrupt; d.data = data;
        return d;
    endfunction

    // One clock: sample pop request mid-cycle, apply FIFO pop/refresh after the edge.
    task automatic step(output bit popped);
        @(negedge clk);
        popped = a_rd_en;
        @(posedge clk);
        #1;
        if (popped && afifo.size() > 0) void'(afifo.pop_front());
        a_empty = (afifo.size() == 0);
        a_data  = a_empty ? '0 : afifo[0];
    endtask

    task automatic tick();
        bit p;
        step(p);
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget && (expq.size() != 0 || afifo.size() != 0); i++) tick();
        repeat (3) tick();
        check("drain_empty", expq.size(), 0);
    endtask

    // Monitor: handshake ordering, latency and response contents.
    initial begin
        int unsigned cyc, rd_cyc, full_cnt;
        bit outstanding;
        tl_d_t e;
        cyc = 0; rd_cyc = 0; full_cnt = 0; outstanding = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                outstanding = 0;
                check("reset_quiet", {a_rd_en, d_wr_en}, 0);
            end else begin
                if (d_full) check("no_push_when_full", d_wr_en, 0);
                if (a_rd_en) begin
                    check("no_overlap", outstanding, 0);
                    outstanding = 1;
                    rd_cyc   = cyc;
                    full_cnt = 0;
                end else if (d_wr_en) begin
                    check("push_has_request", outstanding, 1);
                    check("latency", cyc - rd_cyc, 2 + full_cnt);
                    check("resp_expected", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("d_resp", d_data, e);
                    end
                    outstanding = 0;
                end else if (outstanding && d_full && cyc >= rd_cyc + 2) begin
                    full_cnt++;
                end
            end
        end
    end

    initial begin
        bit p;
        logic [44:0] held;
        reset_n = 1'b0;
        a_empty = 1'b1;
        a_data  = '0;
        d_full  = 1'b0;
        #1;
        check("reset_a_rd_en", a_rd_en, 0);
        check("reset_d_wr_en", d_wr_en, 0);
        check("reset_d_data", d_data, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Give every word a known value.
        for (int unsigned w = 0; w < (1 << MEM_AW); w++)
            issue(mk(A_PUT_FULL, 2'd2, 4'(w), BASE + 4 * w, 4'hF, $urandom));
        drain(1000);

        // Directed cases with hand-derived responses.
        issue_exp(mk(A_PUT_FULL, 2'd2, 4'd3, BASE + 32'h10, 4'hF, 32'hDEADBEEF),
                  dresp(D_ACK, 2'd2, 4'd3, 0, 0, 0));
        issue_exp(mk(A_GET, 2'd2, 4'd5, BASE + 32'h10, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd5, 0, 0, 32'hDEADBEEF));
        issue_exp(mk(A_PUT_PARTIAL, 2'd0, 4'd6, BASE + 32'h11, 4'b0010, 32'h0000AA00),
                  dresp(D_ACK, 2'd0, 4'd6, 0, 0, 0));
        issue_exp(mk(A_GET, 2'd2, 4'd7, BASE + 32'h10, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd7, 0, 0, 32'hDEADAAEF));
        issue_exp(mk(A_PUT_FULL, 2'd2, 4'd1, BASE, 4'hF, 32'h12345678),
                  dresp(D_ACK, 2'd2, 4'd1, 0, 0, 0));
        issue_exp(mk(A_GET, 2'd2, 4'd2, BASE + NBYTES, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd2, 1, 1, 0));
        issue_exp(mk(A_PUT_FULL, 2'd2, 4'd2, BASE + NBYTES, 4'hF, 32'hCAFEF00D),
                  dresp(D_ACK, 2'd2, 4'd2, 1, 0, 0));
        issue_exp(mk(A_GET, 2'd2, 4'd9, BASE, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd9, 0, 0, 32'h12345678));
        issue_exp(mk(A_GET, 2'd2, 4'd4, BASE + 32'h2, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd4, 1, 1, 0));
        issue_exp(mk(A_ARITH, 2'd2, 4'd8, BASE + 32'h20, 4'hF, 32'h1),
                  dresp(D_ACK, 2'd2, 4'd8, 1, 0, 0));
        issue_exp(mk(A_INTENT, 2'd2, 4'd10, BASE + 32'h20, 4'hF, 32'h1),
                  dresp(D_HINT_ACK, 2'd2, 4'd10, 0, 0, 0));
        drain(200);

        // Backpressure: response held while full, then exactly one push.
        d_full = 1'b1;
        issue_exp(mk(A_GET, 2'd2, 4'd11, BASE + 32'h10, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd11, 0, 0, 32'hDEADAAEF));
        issue(mk(A_GET, 2'd2, 4'd12, BASE, 4'hF, 32'h0));
        repeat (4) tick();
        held = d_data;
        check("held_resp", held, dresp(D_ACK_DATA, 2'd2, 4'd11, 0, 0, 32'hDEADAAEF));
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("held_stable", d_data, held);
        end
        d_full = 1'b0;
        drain(200);

        // Reset during EXEC drops the captured request; the next one survives.
        afifo.push_back(mk(A_GET, 2'd2, 4'd13, BASE + 32'h10, 4'hF, 32'h0));
        issue_exp(mk(A_GET, 2'd2, 4'd14, BASE + 32'h10, 4'hF, 32'h0),
                  dresp(D_ACK_DATA, 2'd2, 4'd14, 0, 0, 32'hDEADAAEF));
        p = 0;
        for (int unsigned i = 0; i < 10 && !p; i++) step(p);
        check("reset_test_popped", p, 1);
        reset_n = 1'b0;
        #1;
        check("abort_a_rd_en", a_rd_en, 0);
        check("abort_d_wr_en", d_wr_en, 0);
        check("abort_d_data", d_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        drain(200);

        // Randomized traffic with random backpressure.
        for (int unsigned i = 0; i < 400; i++) begin
            d_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0 && afifo.size() < 4) issue(rand_req());
            tick();
        end
        d_full = 1'b0;
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
